// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// MEM-stage unit that sits behind the EX/MEM pipeline register. It performs
// word / halfword / byte loads and stores against a data memory through a
// req/ack handshake, stalls the upstream pipeline while an access is
// outstanding, resolves the MEM-stage branch and registers results toward
// MEM/WB.
//
// Ports
//   Clk_in, Rst               clock (rising edge), async active-low reset
//   MemWrite_in, MemRead_in   store / load request (both set = store)
//   MemtoReg_in, RegWrite_in  WB control carried to MEM/WB
//   Branch_in, Zero_in, JR_in branch resolution inputs
//   ALUAddResult_in           branch target
//   ALUResult_in              byte address or ALU result
//   ReadData2_in              store data
//   WriteReg_in               destination register
//   size_in                   00 word, 01 half, 10 byte, 11 word
//   dm_rdata, dm_ack          memory read data / one-cycle completion
//   dm_req, dm_we, dm_addr,
//   dm_be, dm_wdata           memory request, held stable while waiting
//   Stall_out                 hold PC, IF/ID, ID/EX and EX/MEM
//   PCSrc_out,
//   BranchTarget_out          combinational branch decision and target
//   RegWrite_out, MemtoReg_out,
//   ReadData_out, ALUResult_out,
//   WriteReg_out              MEM/WB register
//   Misalign_out, Timeout_out one-cycle error pulses
module mem_access_unit #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        Clk_in,
    input  logic        Rst,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic        Branch_in,
    input  logic        Zero_in,
    input  logic        JR_in,
    input  logic [31:0] ALUAddResult_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] ReadData2_in,
    input  logic [4:0]  WriteReg_in,
    input  logic [1:0]  size_in,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    output logic        Stall_out,
    output logic        PCSrc_out,
    output logic [31:0] BranchTarget_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  WriteReg_out,
    output logic        Misalign_out,
    output logic        Timeout_out
);

    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_WAIT   = 1'b1;
    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] CNT_ONE   = TO_W'(1);

    // Select and sign-extend the addressed lane of a load; word passes through.
    function automatic logic [31:0] fmt_load(input logic [31:0] rd,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  k);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'h00;
        h = 16'h0000;
        r = rd;
        case (sz)
            2'b10: begin
                case (k)
                    2'b00:   b = rd[7:0];
                    2'b01:   b = rd[15:8];
                    2'b10:   b = rd[23:16];
                    2'b11:   b = rd[31:24];
                    default: b = rd[7:0];
                endcase
                r = {{24{b[7]}}, b};
            end
            2'b01: begin
                h = k[1] ? rd[31:16] : rd[15:0];
                r = {{16{h[15]}}, h};
            end
            default: r = rd;
        endcase
        return r;
    endfunction

    logic [0:0]      state_r;
    logic [TO_W-1:0] count_r;
    logic [1:0]      size_r;
    logic [1:0]      lane_r;

    logic        mem_op_s;
    logic        is_half_s;
    logic        is_byte_s;
    logic        is_word_s;
    logic        misalign_s;
    logic        timeout_hit_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    assign mem_op_s      = MemRead_in | MemWrite_in;
    assign is_half_s     = (size_in == 2'b01);
    assign is_byte_s     = (size_in == 2'b10);
    assign is_word_s     = ~is_half_s & ~is_byte_s;
    assign misalign_s    = (is_half_s & ALUResult_in[0]) |
                           (is_word_s & (ALUResult_in[1:0] != 2'b00));
    assign timeout_hit_s = (state_r == ST_WAIT) && (count_r == TIMEOUT_C);

    assign PCSrc_out        = Branch_in & Zero_in & ~JR_in;
    assign BranchTarget_out = ALUAddResult_in;

    // Byte enables and lane-replicated write data for the current request.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = ReadData2_in;
        if (is_byte_s) begin
            case (ALUResult_in[1:0])
                2'b00:   be_s = 4'b0001;
                2'b01:   be_s = 4'b0010;
                2'b10:   be_s = 4'b0100;
                2'b11:   be_s = 4'b1000;
                default: be_s = 4'b0001;
            endcase
            wdata_s = {4{ReadData2_in[7:0]}};
        end else if (is_half_s) begin
            be_s    = ALUResult_in[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{ReadData2_in[15:0]}};
        end else begin
            be_s    = 4'b1111;
            wdata_s = ReadData2_in;
        end
    end

    // Upstream stall: issuing in IDLE, or waiting without ack and not yet timed out.
    always_comb begin
        Stall_out = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s && !misalign_s) begin
                    Stall_out = 1'b1;
                end else begin
                    Stall_out = 1'b0;
                end
            end
            ST_WAIT: begin
                if (!dm_ack && !timeout_hit_s) begin
                    Stall_out = 1'b1;
                end else begin
                    Stall_out = 1'b0;
                end
            end
            default: Stall_out = 1'b0;
        endcase
    end

    // Access FSM: latch the request on entry to WAIT, hold it until ack or timeout.
    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst) begin
            state_r  <= ST_IDLE;
            count_r  <= '0;
            size_r   <= 2'b00;
            lane_r   <= 2'b00;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= 32'h0000_0000;
            dm_be    <= 4'b0000;
            dm_wdata <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s && !misalign_s) begin
                        state_r  <= ST_WAIT;
                        count_r  <= '0;
                        size_r   <= size_in;
                        lane_r   <= ALUResult_in[1:0];
                        dm_req   <= 1'b1;
                        dm_we    <= MemWrite_in;
                        dm_addr  <= {ALUResult_in[31:2], 2'b00};
                        dm_be    <= be_s;
                        dm_wdata <= wdata_s;
                    end else begin
                        state_r <= ST_IDLE;
                        dm_req  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (dm_ack || timeout_hit_s) begin
                        state_r <= ST_IDLE;
                        dm_req  <= 1'b0;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    dm_req  <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB register: pass-through, completed access, or bubble.
    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst) begin
            RegWrite_out  <= 1'b0;
            MemtoReg_out  <= 1'b0;
            ReadData_out  <= 32'h0000_0000;
            ALUResult_out <= 32'h0000_0000;
            WriteReg_out  <= 5'd0;
        end else if ((state_r == ST_IDLE && !mem_op_s) ||
                     (state_r == ST_WAIT && dm_ack)) begin
            RegWrite_out  <= RegWrite_in;
            MemtoReg_out  <= MemtoReg_in;
            ALUResult_out <= ALUResult_in;
            WriteReg_out  <= WriteReg_in;
            // Only a completed load carries memory data; stores and ALU ops return 0.
            if (state_r == ST_WAIT && !dm_we) begin
                ReadData_out <= fmt_load(dm_rdata, size_r, lane_r);
            end else begin
                ReadData_out <= 32'h0000_0000;
            end
        end else begin
            RegWrite_out  <= 1'b0;
            MemtoReg_out  <= 1'b0;
            ReadData_out  <= 32'h0000_0000;
            ALUResult_out <= 32'h0000_0000;
            WriteReg_out  <= 5'd0;
        end
    end

    // One-cycle error pulses; an ack in the timeout cycle counts as completion.
    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst) begin
            Misalign_out <= 1'b0;
            Timeout_out  <= 1'b0;
        end else begin
            Misalign_out <= (state_r == ST_IDLE) && mem_op_s && misalign_s;
            Timeout_out  <= timeout_hit_s && !dm_ack;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (TIMEOUT overridden to 4).
module tb_mem_access_unit;

    logic        Clk_in;
    logic        Rst;
    logic        MemWrite_in;
    logic        MemRead_in;
    logic        MemtoReg_in;
    logic        RegWrite_in;
    logic        Branch_in;
    logic        Zero_in;
    logic        JR_in;
    logic [31:0] ALUAddResult_in;
    logic [31:0] ALUResult_in;
    logic [31:0] ReadData2_in;
    logic [4:0]  WriteReg_in;
    logic [1:0]  size_in;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        Stall_out;
    logic        PCSrc_out;
    logic [31:0] BranchTarget_out;
    logic        RegWrite_out;
    logic        MemtoReg_out;
    logic [31:0] ReadData_out;
    logic [31:0] ALUResult_out;
    logic [4:0]  WriteReg_out;
    logic        Misalign_out;
    logic        Timeout_out;

    int pass_cnt;
    int chk_cnt;

    mem_access_unit #(.TO_W(8), .TIMEOUT(4)) dut (
        .Clk_in(Clk_in), .Rst(Rst),
        .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .Branch_in(Branch_in), .Zero_in(Zero_in), .JR_in(JR_in),
        .ALUAddResult_in(ALUAddResult_in), .ALUResult_in(ALUResult_in),
        .ReadData2_in(ReadData2_in), .WriteReg_in(WriteReg_in),
        .size_in(size_in), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .Stall_out(Stall_out), .PCSrc_out(PCSrc_out),
        .BranchTarget_out(BranchTarget_out), .RegWrite_out(RegWrite_out),
        .MemtoReg_out(MemtoReg_out), .ReadData_out(ReadData_out),
        .ALUResult_out(ALUResult_out), .WriteReg_out(WriteReg_out),
        .Misalign_out(Misalign_out), .Timeout_out(Timeout_out)
    );

    initial Clk_in = 1'b0;
    always #5 Clk_in = ~Clk_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic clear_inputs();
        MemWrite_in     = 1'b0;
        MemRead_in      = 1'b0;
        MemtoReg_in     = 1'b0;
        RegWrite_in     = 1'b0;
        Branch_in       = 1'b0;
        Zero_in         = 1'b0;
        JR_in           = 1'b0;
        ALUAddResult_in = 32'h0;
        ALUResult_in    = 32'h0;
        ReadData2_in    = 32'h0;
        WriteReg_in     = 5'd0;
        size_in         = 2'b00;
    endtask

    // Issue one aligned access at a negedge, ack it in WAIT cycle ack_at,
    // return at the negedge after completion with inputs cleared.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdata, input int ack_at,
                              output int stalls, output logic cap_req,
                              output logic cap_we, output logic [31:0] cap_addr,
                              output logic [3:0] cap_be, output logic [31:0] cap_wdata);
        MemRead_in   = rd;
        MemWrite_in  = wr;
        size_in      = sz;
        ALUResult_in = addr;
        ReadData2_in = wd;
        RegWrite_in  = rd & ~wr;
        MemtoReg_in  = rd & ~wr;
        WriteReg_in  = 5'd9;
        stalls = 0;
        #1;
        if (Stall_out) stalls++;
        @(negedge Clk_in);
        cap_req   = dm_req;
        cap_we    = dm_we;
        cap_addr  = dm_addr;
        cap_be    = dm_be;
        cap_wdata = dm_wdata;
        for (int c = 1; c <= ack_at; c++) begin
            if (c > 1) @(negedge Clk_in);
            if (c == ack_at) begin
                dm_ack   = 1'b1;
                dm_rdata = rdata;
            end
            #1;
            if (Stall_out) stalls++;
        end
        @(negedge Clk_in);
        dm_ack = 1'b0;
        clear_inputs();
    endtask

    int          stalls;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [3:0]  c_be;
    logic [31:0] c_wdata;
    int          req_cnt;
    int          to_cnt;
    int          to_rw_bad;

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        Rst      = 1'b0;
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        clear_inputs();

        // Reset state
        #3;
        check_eq("rst_req", dm_req, 1'b0);
        check_eq("rst_stall", Stall_out, 1'b0);
        check_eq("rst_regwrite", RegWrite_out, 1'b0);
        check_eq("rst_alures", ALUResult_out, 32'h0);
        @(negedge Clk_in);
        @(negedge Clk_in);
        Rst = 1'b1;

        // Plain ALU op
        RegWrite_in  = 1'b1;
        ALUResult_in = 32'h1234;
        WriteReg_in  = 5'd5;
        #1;
        check_eq("alu_stall", Stall_out, 1'b0);
        @(negedge Clk_in);
        check_eq("alu_regwrite", RegWrite_out, 1'b1);
        check_eq("alu_result", ALUResult_out, 32'h1234);
        check_eq("alu_wreg", WriteReg_out, 5'd5);
        check_eq("alu_rdata", ReadData_out, 32'h0);
        check_eq("alu_stall2", Stall_out, 1'b0);
        clear_inputs();
        @(negedge Clk_in);

        // lw 0x40, ack in third WAIT cycle
        run_access(1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 32'hDEADBEEF, 3,
                   stalls, c_req, c_we, c_addr, c_be, c_wdata);
        check_eq("lw_req", c_req, 1'b1);
        check_eq("lw_we", c_we, 1'b0);
        check_eq("lw_addr", c_addr, 32'h40);
        check_eq("lw_be", c_be, 4'b1111);
        check_eq("lw_stalls", stalls, 3);
        check_eq("lw_rdata", ReadData_out, 32'hDEADBEEF);
        check_eq("lw_regwrite", RegWrite_out, 1'b1);
        check_eq("lw_memtoreg", MemtoReg_out, 1'b1);
        check_eq("lw_wreg", WriteReg_out, 5'd9);
        check_eq("lw_req_after", dm_req, 1'b0);

        // lb 0x43 (negative byte), minimum cost
        run_access(1'b1, 1'b0, 2'b10, 32'h43, 32'h0, 32'h80FF1122, 1,
                   stalls, c_req, c_we, c_addr, c_be, c_wdata);
        check_eq("lb3_be", c_be, 4'b1000);
        check_eq("lb3_addr", c_addr, 32'h40);
        check_eq("lb3_rdata", ReadData_out, 32'hFFFFFF80);
        check_eq("lb3_stalls", stalls, 1);

        // lb 0x41 (positive byte)
        run_access(1'b1, 1'b0, 2'b10, 32'h41, 32'h0, 32'h80FF1122, 2,
                   stalls, c_req, c_we, c_addr, c_be, c_wdata);
        check_eq("lb1_be", c_be, 4'b0010);
        check_eq("lb1_rdata", ReadData_out, 32'h00000011);

        // lh 0x42
        run_access(1'b1, 1'b0, 2'b01, 32'h42, 32'h0, 32'h80FF1122, 1,
                   stalls, c_req, c_we, c_addr, c_be, c_wdata);
        check_eq("lh_be", c_be, 4'b1100);
        check_eq("lh_rdata", ReadData_out, 32'hFFFF80FF);

        // sb 0x105
        run_access(1'b0, 1'b1, 2'b10, 32'h105, 32'h000000AB, 32'h0, 1,
                   stalls, c_req, c_we, c_addr, c_be, c_wdata);
        check_eq("sb_we", c_we, 1'b1);
        check_eq("sb_be", c_be, 4'b0010);
        check_eq("sb_wdata", c_wdata, 32'hABABABAB);
        check_eq("sb_addr", c_addr, 32'h104);
        check_eq("sb_regwrite", RegWrite_out, 1'b0);
        check_eq("sb_rdata", ReadData_out, 32'h0);

        // sh 0x102
        run_access(1'b0, 1'b1, 2'b01, 32'h102, 32'h12345678, 32'h0, 1,
                   stalls, c_req, c_we, c_addr, c_be, c_wdata);
        check_eq("sh_be", c_be, 4'b1100);
        check_eq("sh_wdata", c_wdata, 32'h56785678);

        // Read and write both set: treated as a word store
        run_access(1'b1, 1'b1, 2'b11, 32'h208, 32'hCAFEF00D, 32'h0, 1,
                   stalls, c_req, c_we, c_addr, c_be, c_wdata);
        check_eq("rw_we", c_we, 1'b1);
        check_eq("rw_be", c_be, 4'b1111);
        check_eq("rw_wdata", c_wdata, 32'hCAFEF00D);

        // Ack in the same cycle as the timeout limit wins
        run_access(1'b1, 1'b0, 2'b00, 32'h80, 32'h0, 32'h0BADCAFE, 5,
                   stalls, c_req, c_we, c_addr, c_be, c_wdata);
        check_eq("lateack_timeout", Timeout_out, 1'b0);
        check_eq("lateack_rdata", ReadData_out, 32'h0BADCAFE);
        check_eq("lateack_stalls", stalls, 5);

        // Misaligned lw 0x42
        MemRead_in   = 1'b1;
        RegWrite_in  = 1'b1;
        MemtoReg_in  = 1'b1;
        ALUResult_in = 32'h42;
        size_in      = 2'b00;
        #1;
        check_eq("mis_lw_stall", Stall_out, 1'b0);
        @(negedge Clk_in);
        check_eq("mis_lw_pulse", Misalign_out, 1'b1);
        check_eq("mis_lw_regwrite", RegWrite_out, 1'b0);
        check_eq("mis_lw_memtoreg", MemtoReg_out, 1'b0);
        check_eq("mis_lw_req", dm_req, 1'b0);
        clear_inputs();
        @(negedge Clk_in);
        check_eq("mis_lw_once", Misalign_out, 1'b0);

        // Misaligned sh 0x41
        MemWrite_in  = 1'b1;
        ALUResult_in = 32'h41;
        size_in      = 2'b01;
        #1;
        check_eq("mis_sh_stall", Stall_out, 1'b0);
        @(negedge Clk_in);
        check_eq("mis_sh_pulse", Misalign_out, 1'b1);
        check_eq("mis_sh_req", dm_req, 1'b0);
        clear_inputs();
        @(negedge Clk_in);

        // Stray ack in IDLE is ignored
        dm_ack       = 1'b1;
        RegWrite_in  = 1'b1;
        ALUResult_in = 32'h77;
        @(negedge Clk_in);
        dm_ack = 1'b0;
        check_eq("stray_req", dm_req, 1'b0);
        check_eq("stray_alures", ALUResult_out, 32'h77);
        clear_inputs();
        @(negedge Clk_in);

        // Timeout with no ack
        MemRead_in   = 1'b1;
        RegWrite_in  = 1'b1;
        ALUResult_in = 32'h80;
        size_in      = 2'b00;
        req_cnt   = 0;
        to_cnt    = 0;
        to_rw_bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk_in);
            if (dm_req) req_cnt++;
            if (Timeout_out) begin
                to_cnt++;
                if (RegWrite_out) to_rw_bad++;
            end
            if (!Stall_out) clear_inputs();
        end
        check_eq("to_req_cycles", req_cnt, 5);
        check_eq("to_pulses", to_cnt, 1);
        check_eq("to_bubble", to_rw_bad, 0);
        check_eq("to_stall_rel", Stall_out, 1'b0);

        // Reset in the middle of WAIT
        MemWrite_in  = 1'b1;
        ALUResult_in = 32'h200;
        ReadData2_in = 32'h11223344;
        RegWrite_in  = 1'b1;
        @(negedge Clk_in);
        @(negedge Clk_in);
        check_eq("mid_req_before", dm_req, 1'b1);
        #2;
        Rst = 1'b0;
        clear_inputs();
        #1;
        check_eq("mid_req", dm_req, 1'b0);
        check_eq("mid_we", dm_we, 1'b0);
        check_eq("mid_addr", dm_addr, 32'h0);
        check_eq("mid_be", dm_be, 4'b0000);
        check_eq("mid_stall", Stall_out, 1'b0);
        check_eq("mid_regwrite", RegWrite_out, 1'b0);
        @(negedge Clk_in);
        Rst = 1'b1;
        @(negedge Clk_in);
        check_eq("mid_after_req", dm_req, 1'b0);

        // Branch resolution
        Branch_in       = 1'b1;
        Zero_in         = 1'b1;
        JR_in           = 1'b0;
        ALUAddResult_in = 32'h200;
        #1;
        check_eq("br_pcsrc", PCSrc_out, 1'b1);
        check_eq("br_target", BranchTarget_out, 32'h200);
        JR_in = 1'b1;
        #1;
        check_eq("br_jr_pcsrc", PCSrc_out, 1'b0);
        JR_in   = 1'b0;
        Zero_in = 1'b0;
        #1;
        check_eq("br_nz_pcsrc", PCSrc_out, 1'b0);
        clear_inputs();
        @(negedge Clk_in);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. It performs loads and stores of word, halfword or byte size against a data memory through a req/ack handshake. It stalls the upstream pipeline while an access is outstanding, resolves the MEM-stage branch, and registers results toward MEM/WB.

Parameters:
TO_W, 8, width of the ack-timeout counter
TIMEOUT, 255, cycles in WAIT without ack before the access is aborted (1..2^TO_W-1)

Ports:
Clk_in  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-low (Rst=0 resets)
MemWrite_in  in  1  store request from EX/MEM
MemRead_in  in  1  load request from EX/MEM
MemtoReg_in  in  1  WB selects memory data
RegWrite_in  in  1  WB register write enable
Branch_in  in  1  branch instruction
Zero_in  in  1  ALU zero flag
JR_in  in  1  jump-register instruction
ALUAddResult_in  in  32  branch target
ALUResult_in  in  32  byte address or ALU result
ReadData2_in  in  32  store data
WriteReg_in  in  5  destination register
size_in  in  2  00 word, 01 half, 10 byte, 11 treated as word
dm_rdata  in  32  memory read data, valid with dm_ack
dm_ack  in  1  memory completion, one cycle
dm_req  out  1  access request
dm_we  out  1  1 = write
dm_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dm_be  out  4  byte enables, bit i = bits 8i+7:8i
dm_wdata  out  32  lane-replicated store data
Stall_out  out  1  hold PC, IF/ID, ID/EX and EX/MEM
PCSrc_out  out  1  Branch_in & Zero_in & ~JR_in (combinational)
BranchTarget_out  out  32  ALUAddResult_in passthrough
RegWrite_out  out  1  to MEM/WB
MemtoReg_out  out  1  to MEM/WB
ReadData_out  out  32  formatted load data
ALUResult_out  out  32  to MEM/WB
WriteReg_out  out  5  to MEM/WB
Misalign_out  out  1  one-cycle pulse, misaligned access dropped
Timeout_out  out  1  one-cycle pulse, access aborted

Behaviour:
- Reset (Rst=0, asynchronous):
  - All registered outputs go to 0 and the state goes to IDLE.
  - dm_req drops immediately, even with an access in flight; no completion is reported.
- Memory op: mem_op = MemRead_in | MemWrite_in.
- Alignment rule:
  - misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
  - MemRead_in and MemWrite_in both set is treated as a store.
- FSM states: IDLE and WAIT.
- IDLE, no mem_op:
  - On the next edge, MEM/WB outputs load the inputs (ReadData_out=0).
  - Latency is 1 cycle; Stall_out=0.
- IDLE, mem_op and misaligned:
  - No access is issued; Stall_out=0.
  - On the next edge: Misalign_out=1 for 1 cycle, and the MEM/WB entry is a bubble (RegWrite_out=0, MemtoReg_out=0).
- IDLE, mem_op and aligned:
  - Stall_out=1 combinationally.
  - On the edge: latch dm_addr, dm_we, dm_be, dm_wdata; clear the timeout counter; go to WAIT. MEM/WB loads a bubble.
- WAIT:
  - dm_req=1 and all dm_* outputs are held stable.
  - Stall_out = ~dm_ack & ~(count==TIMEOUT).
  - On dm_ack: MEM/WB loads the instruction, with ReadData_out set to the formatted dm_rdata for loads and 0 for stores; go to IDLE. Upstream advances on the same edge.
  - Minimum load/store cost: 1 stall cycle.
- Timeout:
  - In WAIT with no ack, the counter increments each cycle.
  - At count==TIMEOUT: Stall_out=0, dm_req is dropped on the edge, Timeout_out pulses, MEM/WB loads a bubble, go to IDLE.
  - A dm_ack arriving in that same cycle wins: normal completion, no Timeout_out.
- Stray ack: dm_ack in IDLE is ignored.
- Store lanes (little-endian, k = addr[1:0]):
  - byte: dm_be = 1<<k, dm_wdata = {4{ReadData2_in[7:0]}}.
  - half: dm_be = addr[1] ? 1100 : 0011, dm_wdata = {2{ReadData2_in[15:0]}}.
  - word: dm_be = 1111, dm_wdata = ReadData2_in.
- Load format:
  - The selected byte or half lane is sign-extended to 32 bits; word loads pass through.
  - Lane selection uses the address latched on entry to WAIT.
- Reads: dm_be is still driven per size, for observability.
- Branch: PCSrc_out and BranchTarget_out are combinational and independent of the FSM. Stall handling is the hazard unit's concern.

Test Plan:
- ALU op, RegWrite_in=1, ALUResult_in=0x1234, WriteReg_in=5 -> next cycle: RegWrite_out=1, ALUResult_out=0x1234, WriteReg_out=5, Stall_out never 1.
- lw to addr 0x40, ack 3 cycles after req, dm_rdata=0xDEADBEEF -> dm_addr=0x40, dm_be=1111, Stall_out high 3 cycles, then ReadData_out=0xDEADBEEF, RegWrite_out=1.
- lb to addr 0x43, dm_rdata=0x80FF1122 -> dm_be=1000, ReadData_out=0xFFFFFF80. Same with lh to 0x42 -> dm_be=1100, ReadData_out=0xFFFF80FF.
- sb to addr 0x105, ReadData2_in=0x000000AB -> dm_we=1, dm_be=0010, dm_wdata=0xABABABAB, dm_addr=0x104; after ack RegWrite_out=0.
- lw to addr 0x42 -> no dm_req, Misalign_out pulses once, RegWrite_out=0, no stall. sh to 0x41 gives the same response.
- TIMEOUT=4, no ack -> dm_req high 5 cycles, Timeout_out pulse, Stall_out released. Rst=0 asserted mid-WAIT -> dm_req=0 immediately and all outputs 0.
- Branch_in=1, Zero_in=1, JR_in=0, ALUAddResult_in=0x200 -> PCSrc_out=1, BranchTarget_out=0x200 in the same cycle. With JR_in=1 -> PCSrc_out=0.
